// File: rtl/pipelined_rca_addsub_if.sv
// pipelined_rca_addsub_if
//   Handshake and data bundle for pipelined_rca_addsub.
//   Producer side: inValid/inReady, a, b, carryInput, sub.
//   Consumer side: outValid/outReady, sum, carryOutput (+ overflow).
//   The master modport is the environment: producer plus consumer.
//   The slave modport is the adder.
//   Optional macro OVERFLOW_FLAG_EN adds the 1-bit overflow result signal.
interface pipelined_rca_addsub_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryInput;
  logic             sub;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             carryOutput;
`ifdef OVERFLOW_FLAG_EN
  logic             overflow;

  modport master (
    output inValid, a, b, carryInput, sub, outReady,
    input  inReady, outValid, sum, carryOutput, overflow
  );
  modport slave (
    input  inValid, a, b, carryInput, sub, outReady,
    output inReady, outValid, sum, carryOutput, overflow
  );
`else
  modport master (
    output inValid, a, b, carryInput, sub, outReady,
    input  inReady, outValid, sum, carryOutput
  );
  modport slave (
    input  inValid, a, b, carryInput, sub, outReady,
    output inReady, outValid, sum, carryOutput
  );
`endif
endinterface

// File: rtl/pipelined_rca_addsub.sv
// pipelined_rca_addsub
//   WIDTH-bit add/subtract, split into STAGES ripple chunks of CW = WIDTH/STAGES
//   bits. There is one register boundary per chunk. A valid/ready handshake
//   with per-stage bubble collapse sustains one operation per cycle. Latency is
//   STAGES cycles.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pipelined_rca_addsub_if.slave:
//            inValid/inReady, a, b, carryInput, sub -> operands in
//            outValid/outReady, sum, carryOutput    -> result out
//   Optional macro OVERFLOW_FLAG_EN adds bus.overflow. This is the signed
//   two's-complement overflow flag, and it is registered with the last chunk.
module pipelined_rca_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_rca_addsub_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] carry_vec;
  logic [STAGES-1:0] ready;      // stage k can load this cycle
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  // Subtraction is a + ~b + 1. B is inverted once, at entry, so later
  // stages never need to know about sub.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.carryInput;

  // The ready chain is evaluated from the output end back to the input.
  // An empty stage is always ready, which collapses bubbles.
  always_comb begin
    ready = '0;
    ready[STAGES-1] = !valid_vec[STAGES-1] || bus.outReady;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ready[k] = !valid_vec[k] || ready[k+1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage
    logic [CW-1:0]         ca;
    logic [CW-1:0]         cb;
    logic                  cin;
    logic                  up_valid;
    logic                  load;
    logic [CW:0]           chunk;
    logic                  v_reg;
    logic                  c_reg;
    logic [(gi+1)*CW-1:0]  res_reg;  // completed sum chunks 0..gi

    assign chunk = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, cin};
    assign load  = ready[gi] && up_valid;

    assign valid_vec[gi] = v_reg;
    assign carry_vec[gi] = c_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
      end else begin
        if (ready[gi]) begin
          v_reg <= up_valid;
        end
        if (load) begin
          c_reg <= chunk[CW];
        end
      end
    end

    if (gi == 0) begin : g_src
      assign ca       = bus.a[CW-1:0];
      assign cb       = b_eff[CW-1:0];
      assign cin      = cin_eff;
      assign up_valid = bus.inValid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg <= '0;
        end else if (load) begin
          res_reg <= chunk[CW-1:0];
        end
      end
    end else begin : g_src
      assign ca       = stage[gi-1].g_ops.op_a_reg[CW-1:0];
      assign cb       = stage[gi-1].g_ops.op_b_reg[CW-1:0];
      assign cin      = carry_vec[gi-1];
      assign up_valid = valid_vec[gi-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg <= '0;
        end else if (load) begin
          res_reg <= {chunk[CW-1:0], stage[gi-1].res_reg};
        end
      end
    end

    // The operand chunks that are still unconsumed travel skewed behind
    // the completed sum chunks. The last stage has nothing left to carry.
    if (gi < STAGES - 1) begin : g_ops
      localparam int OW = WIDTH - (gi + 1) * CW;
      logic [OW-1:0] up_a;
      logic [OW-1:0] up_b;
      logic [OW-1:0] op_a_reg;
      logic [OW-1:0] op_b_reg;

      if (gi == 0) begin : g_in
        assign up_a = bus.a[WIDTH-1:CW];
        assign up_b = b_eff[WIDTH-1:CW];
      end else begin : g_in
        assign up_a = stage[gi-1].g_ops.op_a_reg[WIDTH-gi*CW-1:CW];
        assign up_b = stage[gi-1].g_ops.op_b_reg[WIDTH-gi*CW-1:CW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_a_reg <= '0;
          op_b_reg <= '0;
        end else if (load) begin
          op_a_reg <= up_a;
          op_b_reg <= up_b;
        end
      end
    end
  end

  assign bus.inReady     = ready[0];
  assign bus.outValid    = valid_vec[STAGES-1];
  assign bus.sum         = stage[STAGES-1].res_reg;
  assign bus.carryOutput = carry_vec[STAGES-1];

`ifdef OVERFLOW_FLAG_EN
  // The MSB carry-in differs from the carry-out exactly when both operand
  // MSBs agree but the result MSB differs. B here is the effective
  // (inverted) operand.
  logic ovf_reg;
  logic ovf_next;

  assign ovf_next =
      (stage[STAGES-1].ca[CW-1] == stage[STAGES-1].cb[CW-1]) &&
      (stage[STAGES-1].chunk[CW-1] != stage[STAGES-1].ca[CW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (stage[STAGES-1].load) begin
      ovf_reg <= ovf_next;
    end
  end

  assign bus.overflow = ovf_reg;
`else
`endif
endmodule

// File: tb/tb_pipelined_rca_addsub.sv
module tb_pipelined_rca_addsub;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_rca_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_rca_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   out_count = 0;
  int   base;
  res_t exp_q[$];
  res_t mon_exp;
  res_t pin_r;

  // Reference: plain integer arithmetic on the operation that was selected.
  function automatic res_t model(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    res_t        r;
    longint      sa, sb, sr;
    logic [32:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.sum  = full[31:0];
      r.cout = full[32];
      sr     = sa + sb + longint'(cin);
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle a result is presented, check it against the
  // oldest accepted operation. Accepted operations are queued here.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.outValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum 0x%h with no result pending", bus.sum);
        end else begin
          mon_exp = exp_q[0];
`ifdef OVERFLOW_FLAG_EN
          chk("model_result", 64'({bus.overflow, bus.carryOutput, bus.sum}),
              64'({mon_exp.ovf, mon_exp.cout, mon_exp.sum}));
`else
          chk("model_result", 64'({bus.carryOutput, bus.sum}),
              64'({mon_exp.cout, mon_exp.sum}));
`endif
          if (bus.outReady) begin
            void'(exp_q.pop_front());
          end
        end
        if (bus.outReady) out_count++;
      end
      if (bus.inValid && bus.inReady) begin
        exp_q.push_back(model(bus.a, bus.b, bus.carryInput, bus.sub));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    bus.inValid    = v;
    bus.a          = a;
    bus.b          = b;
    bus.carryInput = cin;
    bus.sub        = sub;
  endtask

  task automatic drive_rand();
    drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Single op into an empty pipe. The result must be absent for STAGES-1
  // edges and then present.
  task automatic directed(string name, logic [31:0] a, logic [31:0] b, logic cin,
                          logic sub, logic [31:0] es, logic ec, logic eo);
    bus.outReady = 1'b1;
    drive(1'b1, a, b, cin, sub);
    tick();
    bus.inValid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      chk({name, "_early"}, 64'(bus.outValid), 64'(0));
      tick();
    end
    chk({name, "_valid"}, 64'(bus.outValid), 64'(1));
    chk({name, "_sum"}, 64'(bus.sum), 64'(es));
    chk({name, "_carry"}, 64'(bus.carryOutput), 64'(ec));
`ifdef OVERFLOW_FLAG_EN
    chk({name, "_ovf"}, 64'(bus.overflow), 64'(eo));
`else
    if (eo === 1'bx) $display("note: %s overflow unused", name);
`endif
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.outReady = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outvalid", 64'(bus.outValid), 64'(0));
    chk("reset_sum", 64'(bus.sum), 64'(0));
    chk("reset_carry", 64'(bus.carryOutput), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("reset_inready", 64'(bus.inReady), 64'(1));

    // Pin the reference model with hand-computed values.
    pin_r = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("pin_add_wrap", 64'(pin_r), 64'({1'b0, 1'b1, 32'h0}));
    pin_r = model(32'd5, 32'd7, 1'b0, 1'b1);
    chk("pin_sub_borrow", 64'(pin_r), 64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
    pin_r = model(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    chk("pin_sub_ovf", 64'(pin_r), 64'({1'b1, 1'b1, 32'h7FFF_FFFF}));
    pin_r = model(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    chk("pin_add_cin_ovf", 64'(pin_r), 64'({1'b1, 1'b0, 32'h8000_0000}));

    directed("add_ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-to-back streaming: one accept and, once full, one result per cycle.
    base = out_count;
    bus.outReady = 1'b1;
    for (int i = 0; i < 16 + STAGES; i++) begin
      if (i < 16) drive_rand();
      else bus.inValid = 1'b0;
      @(negedge clk);
      if (i < 16) chk("stream_inready", 64'(bus.inReady), 64'(1));
      if (i >= STAGES) chk("stream_outvalid", 64'(bus.outValid), 64'(1));
      tick();
    end
    chk("stream_count", 64'(out_count - base), 64'(16));

    // Backpressure: fill, stall for 5 cycles, then drain.
    base = out_count;
    bus.outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      @(negedge clk);
      chk("bp_fill_inready", 64'(bus.inReady), 64'(1));
      tick();
    end
    drive_rand();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_full_inready", 64'(bus.inReady), 64'(0));
      chk("bp_full_outvalid", 64'(bus.outValid), 64'(1));
      tick();
    end
    bus.outReady = 1'b1;
    @(negedge clk);
    chk("bp_release_inready", 64'(bus.inReady), 64'(1));
    tick();
    bus.inValid = 1'b0;
    repeat (8) tick();
    chk("bp_count", 64'(out_count - base), 64'(5));

    // Bubble collapse: ops at cycles 0, 2 and 3, with the output stalled.
    base = out_count;
    bus.outReady = 1'b0;
    drive_rand();
    @(negedge clk);
    chk("bub_c0_inready", 64'(bus.inReady), 64'(1));
    tick();
    bus.inValid = 1'b0;
    tick();
    drive_rand();
    @(negedge clk);
    chk("bub_c2_inready", 64'(bus.inReady), 64'(1));
    tick();
    drive_rand();
    @(negedge clk);
    chk("bub_c3_inready", 64'(bus.inReady), 64'(1));
    tick();
    drive_rand();
    @(negedge clk);
    chk("bub_collapse_inready", 64'(bus.inReady), 64'(1));
    tick();
    drive_rand();
    @(negedge clk);
    chk("bub_full_inready", 64'(bus.inReady), 64'(0));
    tick();
    bus.outReady = 1'b1;
    @(negedge clk);
    chk("bub_release_inready", 64'(bus.inReady), 64'(1));
    tick();
    bus.inValid = 1'b0;
    repeat (8) tick();
    chk("bub_count", 64'(out_count - base), 64'(5));

    // Async reset with three operations in flight.
    bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pick(), pick(), 1'($urandom), 1'($urandom));
      tick();
    end
    bus.inValid = 1'b0;
    repeat (2) tick();
    chk("rst_preload_outvalid", 64'(bus.outValid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outvalid", 64'(bus.outValid), 64'(0));
    chk("rst_async_sum", 64'(bus.sum), 64'(0));
    chk("rst_async_carry", 64'(bus.carryOutput), 64'(0));
    chk("rst_async_inready", 64'(bus.inReady), 64'(1));
    #2 rst_n = 1'b1;
    bus.outReady = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("rst_no_stale", 64'(bus.outValid), 64'(0));
      tick();
    end
    directed("post_reset", 32'h1234, 32'h1, 1'b0, 1'b0, 32'h1235, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 9) < 7), pick(), pick(), 1'($urandom), 1'($urandom));
      bus.outReady = 1'($urandom_range(0, 9) < 6);
      tick();
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    repeat (STAGES + 6) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("final_outvalid", 64'(bus.outValid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
